// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage.
// Contents: datapath widths, ALU opcode/flag types, operand-select encodings,
// the constant four used for PC+4, and the payload carried through the stage.
package alu_issue_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  // ALU_OP_ADD must stay encoded as zero: the payload register resets to all zeros.
  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SLL  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_SLT  = 4'd8,
    ALU_OP_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

  // Encoding 2'd3 is reserved for both selects and yields a zero operand.
  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_e;

  localparam logic [XLEN-1:0] ALU_CONST_FOUR = XLEN'(4);

  typedef struct packed {
    alu_op_e         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RD_W-1:0] rd;
  } issue_pl_t;

  localparam int unsigned ISSUE_PL_W = $bits(issue_pl_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry (main + skid) valid/ready buffer with a registered in_ready_o.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   in_valid_i/in_ready_o upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i downstream handshake, out_data_o payload (main entry)
// Strictly FIFO: new data never bypasses an occupied skid entry.
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         ready_q, ready_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire, out_fire;

  // Ready is forced low while reset is asserted, independent of the register.
  assign in_ready_o  = ready_q & ~reset_i;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = main_valid_q & out_ready_i;

  // Next-state for both entries; payloads only change when loaded.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) skid_d = in_data_i;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) main_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage front end feeding the combinational alu.
// Selects operands A/B from rs1/pc/0 and rs2/imm/4, buffers {op, A, B, rd} in a
// 2-entry skid buffer, drives the alu from the main entry and forwards the alu
// result/flags with rd to writeback.
// Ports:
//   clk_i, reset_i                          clock, synchronous active-high reset
//   in_valid_i/in_ready_o, in_*             decoded operation input handshake
//   alu_a_o, alu_b_o, alu_op_o              to alu
//   alu_result_i, alu_flags_i               from alu
//   out_valid_o/out_ready_i, out_*          writeback handshake
// Optional (macro ALU_ISSUE_STAGE_PERF_EN):
//   perf_ops_o    saturating count of output handshakes
//   perf_stall_o  saturating count of cycles with out_valid_o & !out_ready_i
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  alu_op_e         in_op_i,
  input  a_sel_e          in_a_sel_i,
  input  b_sel_e          in_b_sel_i,
  input  logic [XLEN-1:0] in_rs1_i,
  input  logic [XLEN-1:0] in_rs2_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic [RD_W-1:0] in_rd_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output alu_op_e         alu_op_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  alu_flags_t      alu_flags_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o,
  output alu_flags_t      out_flags_o,
  output logic [RD_W-1:0] out_rd_o
`ifdef ALU_ISSUE_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_ops_o,
  output logic [31:0]     perf_stall_o
`endif
);

  issue_pl_t              in_pl;
  issue_pl_t              main_pl;
  logic [ISSUE_PL_W-1:0]  main_bits;

  // Operand select on the incoming operation; reserved encodings give zero.
  always_comb begin
    in_pl    = '0;
    in_pl.op = in_op_i;
    in_pl.rd = in_rd_i;
    case (in_a_sel_i)
      A_RS1:   in_pl.a = in_rs1_i;
      A_PC:    in_pl.a = in_pc_i;
      A_ZERO:  in_pl.a = '0;
      default: in_pl.a = '0;
    endcase
    case (in_b_sel_i)
      B_RS2:   in_pl.b = in_rs2_i;
      B_IMM:   in_pl.b = in_imm_i;
      B_FOUR:  in_pl.b = ALU_CONST_FOUR;
      default: in_pl.b = '0;
    endcase
  end

  pipe_skid_buf #(
    .W (ISSUE_PL_W)
  ) u_skid (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_pl),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (main_bits)
  );

  assign main_pl = issue_pl_t'(main_bits);

  // The main entry drives the alu; its result settles within the same cycle.
  assign alu_a_o      = main_pl.a;
  assign alu_b_o      = main_pl.b;
  assign alu_op_o     = main_pl.op;
  assign out_rd_o     = main_pl.rd;
  assign out_result_o = alu_result_i;
  assign out_flags_o  = alu_flags_i;

`ifdef ALU_ISSUE_STAGE_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;
  logic        out_fire;
  logic        out_stall;

  assign out_fire  = out_valid_o & out_ready_i;
  assign out_stall = out_valid_o & ~out_ready_i;

  // Saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_fire && (perf_ops_q != 32'hFFFF_FFFF))
        perf_ops_q <= perf_ops_q + 32'd1;
      if (out_stall && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops_o   = perf_ops_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural alu model and a
// scoreboard of expected {result, rd} per accepted operation.
`timescale 1ns/1ps
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            in_valid_i;
  logic            in_ready_o;
  alu_op_e         in_op_i;
  a_sel_e          in_a_sel_i;
  b_sel_e          in_b_sel_i;
  logic [31:0]     in_rs1_i, in_rs2_i, in_pc_i, in_imm_i;
  logic [4:0]      in_rd_i;
  logic [31:0]     alu_a_o, alu_b_o;
  alu_op_e         alu_op_o;
  logic [31:0]     alu_result_i;
  alu_flags_t      alu_flags_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     out_result_o;
  alu_flags_t      out_flags_o;
  logic [4:0]      out_rd_o;
`ifdef ALU_ISSUE_STAGE_PERF_EN
  logic [31:0]     perf_ops_o, perf_stall_o;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk_i = ~clk_i;

  alu_issue_stage dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_op_i      (in_op_i),
    .in_a_sel_i   (in_a_sel_i),
    .in_b_sel_i   (in_b_sel_i),
    .in_rs1_i     (in_rs1_i),
    .in_rs2_i     (in_rs2_i),
    .in_pc_i      (in_pc_i),
    .in_imm_i     (in_imm_i),
    .in_rd_i      (in_rd_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_op_o     (alu_op_o),
    .alu_result_i (alu_result_i),
    .alu_flags_i  (alu_flags_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_flags_o  (out_flags_o),
    .out_rd_o     (out_rd_o)
`ifdef ALU_ISSUE_STAGE_PERF_EN
    ,
    .perf_ops_o   (perf_ops_o),
    .perf_stall_o (perf_stall_o)
`endif
  );

  function automatic logic [31:0] alu_model(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_XOR: return a ^ b;
      default:    return 32'd0;
    endcase
  endfunction

  // Behavioural stand-in for the downstream combinational alu.
  always_comb begin
    alu_result_i      = alu_model(alu_op_o, alu_a_o, alu_b_o);
    alu_flags_i.zero  = (alu_result_i == 32'd0);
    alu_flags_i.neg   = alu_result_i[31];
    alu_flags_i.carry = 1'b0;
    alu_flags_i.ovf   = 1'b0;
  end

  function automatic logic [31:0] ref_a(a_sel_e s, logic [31:0] rs1, logic [31:0] pc);
    if (s == A_RS1) return rs1;
    if (s == A_PC)  return pc;
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_b(b_sel_e s, logic [31:0] rs2, logic [31:0] imm);
    if (s == B_RS2)  return rs2;
    if (s == B_IMM)  return imm;
    if (s == B_FOUR) return 32'd4;
    return 32'd0;
  endfunction

  task automatic drive_op(input a_sel_e as, input b_sel_e bs, input alu_op_e op,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [4:0] rd);
    in_valid_i = 1'b1;
    in_a_sel_i = as;
    in_b_sel_i = bs;
    in_op_i    = op;
    in_rs1_i   = rs1;
    in_rs2_i   = rs2;
    in_pc_i    = pc;
    in_imm_i   = imm;
    in_rd_i    = rd;
  endtask

  // Pushes the expected result when the current inputs are being accepted.
  task automatic note_in_fire(output bit fired);
    exp_t e;
    fired = 1'b0;
    if (in_valid_i && in_ready_o) begin
      e.res = alu_model(in_op_i, ref_a(in_a_sel_i, in_rs1_i, in_pc_i),
                        ref_b(in_b_sel_i, in_rs2_i, in_imm_i));
      e.rd  = in_rd_i;
      exp_q.push_back(e);
      fired = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    drive_op(A_RS1, B_RS2, ALU_OP_ADD, 0, 0, 0, 0, 0);
    in_valid_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if (in_ready_o !== 1'b0) $display("FAIL reset_ready_low got=%b want=0", in_ready_o);
    else n_pass++;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL reset_handshake got valid=%b ready=%b want 0/1", out_valid_o, in_ready_o);
    else n_pass++;
    n_chk++;
    if (alu_a_o !== 32'd0 || alu_b_o !== 32'd0 || alu_op_o !== ALU_OP_ADD || out_rd_o !== 5'd0)
      $display("FAIL reset_payload got a=%h b=%h op=%0d rd=%0d want 0/0/ADD/0",
               alu_a_o, alu_b_o, alu_op_o, out_rd_o);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_select();
    a_sel_e      ta[4] = '{A_RS1, A_PC, A_ZERO, a_sel_e'(2'd3)};
    b_sel_e      tb[4] = '{B_RS2, B_FOUR, B_IMM, b_sel_e'(2'd3)};
    logic [31:0] ea[4] = '{32'd1200, 32'h100, 32'd0, 32'd0};
    logic [31:0] eb[4] = '{32'd5, 32'd4, 32'hABCD_E000, 32'd0};
    logic [31:0] er[4] = '{32'd1205, 32'h104, 32'hABCD_E000, 32'd0};
    bit fired;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      drive_op(ta[i], tb[i], ALU_OP_ADD, 32'd1200, 32'd5, 32'h100, 32'hABCD_E000, 5'(i + 3));
      @(negedge clk_i);
      n_chk++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0)
        $display("FAIL sel%0d_accept got ready=%b valid=%b want 1/0", i, in_ready_o, out_valid_o);
      else n_pass++;
      note_in_fire(fired);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      @(negedge clk_i);
      n_chk++;
      if (out_valid_o !== 1'b1 || out_result_o !== er[i] || out_rd_o !== 5'(i + 3))
        $display("FAIL sel%0d_out got valid=%b res=%h rd=%0d want 1/%h/%0d",
                 i, out_valid_o, out_result_o, out_rd_o, er[i], i + 3);
      else n_pass++;
      n_chk++;
      if (alu_a_o !== ea[i] || alu_b_o !== eb[i])
        $display("FAIL sel%0d_operands got a=%h b=%h want %h/%h", i, alu_a_o, alu_b_o, ea[i], eb[i]);
      else n_pass++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    bit   fired;
    exp_t e;
    int   n_out = 0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      if (i < 10)
        drive_op(A_RS1, B_RS2, (i % 2 == 1) ? ALU_OP_SUB : ALU_OP_ADD,
                 32'd1200, 32'(i), 32'd0, 32'd0, 5'(i));
      else
        in_valid_i = 1'b0;
      @(negedge clk_i);
      if (i < 10) begin
        n_chk++;
        if (in_ready_o !== 1'b1) $display("FAIL b2b_ready cyc=%0d got=%b want=1", i, in_ready_o);
        else n_pass++;
      end
      if (i >= 1 && i <= 10) begin
        n_chk++;
        if (out_valid_o !== 1'b1) $display("FAIL b2b_valid cyc=%0d got=%b want=1", i, out_valid_o);
        else n_pass++;
      end
      note_in_fire(fired);
      if (out_valid_o && out_ready_i) begin
        n_out++;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra got res=%h want no output", out_result_o);
        else begin
          e = exp_q.pop_front();
          if (out_result_o !== e.res || out_rd_o !== e.rd)
            $display("FAIL b2b_out got res=%h rd=%0d want %h/%0d", out_result_o, out_rd_o, e.res, e.rd);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if (n_out != 10 || exp_q.size() != 0)
      $display("FAIL b2b_count got outs=%0d left=%0d want 10/0", n_out, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    bit   fired;
    exp_t e;
    int   sent  = 0;
    int   n_out = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      out_ready_i = (c >= 5);
      if (sent < 3)
        drive_op(A_RS1, B_IMM, ALU_OP_ADD, 32'(100 * (sent + 1)), 32'd0, 32'd0,
                 32'(sent + 1), 5'(sent + 10));
      else
        in_valid_i = 1'b0;
      @(negedge clk_i);
      if (c >= 2 && c <= 4) begin
        n_chk++;
        if (in_ready_o !== 1'b0 || sent != 2)
          $display("FAIL stall_full cyc=%0d got ready=%b accepted=%0d want 0/2", c, in_ready_o, sent);
        else n_pass++;
      end
      if (c >= 1 && c <= 4) begin
        n_chk++;
        if (out_valid_o !== 1'b1 || out_result_o !== 32'd101 || out_rd_o !== 5'd10 ||
            alu_a_o !== 32'd100 || alu_b_o !== 32'd1)
          $display("FAIL stall_hold cyc=%0d got v=%b res=%h rd=%0d a=%h b=%h want 1/65/10/64/1",
                   c, out_valid_o, out_result_o, out_rd_o, alu_a_o, alu_b_o);
        else n_pass++;
      end
      note_in_fire(fired);
      if (fired) sent++;
      if (out_valid_o && out_ready_i) begin
        n_out++;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL stall_extra got res=%h want no output", out_result_o);
        else begin
          e = exp_q.pop_front();
          if (out_result_o !== e.res || out_rd_o !== e.rd)
            $display("FAIL stall_out got res=%h rd=%0d want %h/%0d", out_result_o, out_rd_o, e.res, e.rd);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if (n_out != 3 || exp_q.size() != 0)
      $display("FAIL stall_drain got outs=%0d left=%0d want 3/0", n_out, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit   fired;
    exp_t e;
    int   n_out = 0;
    out_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i); #1;
      drive_op(A_RS1, B_RS2, ALU_OP_ADD, 32'd777, 32'(c), 32'd0, 32'd0, 5'(20 + c));
      @(negedge clk_i);
      note_in_fire(fired);
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1)
      $display("FAIL rstmid_full got ready=%b valid=%b want 0/1", in_ready_o, out_valid_o);
    else n_pass++;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    n_chk++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL rstmid_after got valid=%b ready=%b want 0/1", out_valid_o, in_ready_o);
    else n_pass++;
    out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_i); #1;
      if (c == 4) drive_op(A_ZERO, B_IMM, ALU_OP_ADD, 32'd9, 32'd9, 32'd9, 32'h55, 5'd31);
      else in_valid_i = 1'b0;
      @(negedge clk_i);
      if (c < 5) begin
        n_chk++;
        if (out_valid_o !== 1'b0) $display("FAIL rstmid_ghost cyc=%0d got valid=%b want 0", c, out_valid_o);
        else n_pass++;
      end
      note_in_fire(fired);
      if (out_valid_o && out_ready_i) begin
        n_out++;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL rstmid_extra got res=%h want no output", out_result_o);
        else begin
          e = exp_q.pop_front();
          if (out_result_o !== e.res || out_rd_o !== e.rd || out_result_o !== 32'h55)
            $display("FAIL rstmid_out got res=%h rd=%0d want %h/%0d", out_result_o, out_rd_o, e.res, e.rd);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if (n_out != 1 || exp_q.size() != 0)
      $display("FAIL rstmid_count got outs=%0d left=%0d want 1/0", n_out, exp_q.size());
    else n_pass++;
  endtask

`ifdef ALU_ISSUE_STAGE_PERF_EN
  task automatic test_perf();
    bit   fired;
    exp_t e;
    int   sent = 0;
    @(posedge clk_i); #1;
    reset_i    = 1'b1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      out_ready_i = (c >= 4);
      if (sent < 4)
        drive_op(A_RS1, B_RS2, ALU_OP_XOR, 32'hF0F0_0000, 32'(sent), 32'd0, 32'd0, 5'(sent));
      else
        in_valid_i = 1'b0;
      @(negedge clk_i);
      note_in_fire(fired);
      if (fired) sent++;
      if (out_valid_o && out_ready_i) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL perf_extra got res=%h want no output", out_result_o);
        else begin
          e = exp_q.pop_front();
          if (out_result_o !== e.res || out_rd_o !== e.rd)
            $display("FAIL perf_out got res=%h rd=%0d want %h/%0d", out_result_o, out_rd_o, e.res, e.rd);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if (perf_ops_o !== 32'd4 || perf_stall_o !== 32'd3)
      $display("FAIL perf_counts got ops=%0d stall=%0d want 4/3", perf_ops_o, perf_stall_o);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_select();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef ALU_ISSUE_STAGE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
